// File: rtl/mc_defs.sv
// Shared encodings for the multi-cycle MIPS control path: states, select codes,
// opcodes/functs and the instruction-class record produced by mc_decode.
package mc_defs;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_RTYPE_EX = 4'd6,
    S_RTYPE_WB = 4'd7,
    S_IMM_EX   = 4'd8,
    S_IMM_WB   = 4'd9,
    S_BEQ_EX   = 4'd10,
    S_JUMP     = 4'd11,
    S_JAL      = 4'd12,
    S_JR       = 4'd13
  } state_e;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] EXT_ZERO = 2'b00;
  localparam logic [1:0] EXT_SIGN = 2'b01;
  localparam logic [1:0] EXT_LUI  = 2'b10;

  localparam logic [1:0] REGDST_RT = 2'b00;
  localparam logic [1:0] REGDST_RD = 2'b01;
  localparam logic [1:0] REGDST_RA = 2'b10;

  localparam logic [1:0] M2R_ALUOUT = 2'b00;
  localparam logic [1:0] M2R_MDR    = 2'b01;
  localparam logic [1:0] M2R_PC     = 2'b10;

  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_4     = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_REG    = 2'b11;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;
  localparam logic [5:0] F_JR  = 6'b001000;

  // Exactly one bit set; nop also covers every undefined op/funct.
  typedef struct packed {
    logic mem;
    logic rtype;
    logic imm;
    logic beq;
    logic j;
    logic jal;
    logic jr;
    logic nop;
  } iclass_t;

endpackage

// File: rtl/mc_decode.sv
// Combinational op/funct decoder: one-hot instruction class plus the ALU
// operation and immediate-extension mode used by the execute states.
module mc_decode
  import mc_defs::*;
(
  input  logic [5:0] op_i,
  input  logic [5:0] funct_i,
  output iclass_t    cls_o,
  output logic [2:0] alu_ctl_o,
  output logic [1:0] ext_op_o
);

  always_comb begin
    cls_o     = '0;
    alu_ctl_o = ALU_ADD;
    ext_op_o  = EXT_SIGN;
    case (op_i)
      OP_RTYPE: begin
        case (funct_i)
          F_ADD:   begin cls_o.rtype = 1'b1; alu_ctl_o = ALU_ADD; end
          F_SUB:   begin cls_o.rtype = 1'b1; alu_ctl_o = ALU_SUB; end
          F_AND:   begin cls_o.rtype = 1'b1; alu_ctl_o = ALU_AND; end
          F_OR:    begin cls_o.rtype = 1'b1; alu_ctl_o = ALU_OR;  end
          F_SLT:   begin cls_o.rtype = 1'b1; alu_ctl_o = ALU_SLT; end
          F_JR:    cls_o.jr = 1'b1;
          default: cls_o.nop = 1'b1;
        endcase
      end
      OP_LW, OP_SW: cls_o.mem = 1'b1;
      OP_BEQ:  begin cls_o.beq = 1'b1; alu_ctl_o = ALU_SUB; end
      OP_ADDI: begin cls_o.imm = 1'b1; alu_ctl_o = ALU_ADD; ext_op_o = EXT_SIGN; end
      OP_ORI:  begin cls_o.imm = 1'b1; alu_ctl_o = ALU_OR;  ext_op_o = EXT_ZERO; end
      // lui relies on rs=0 so that 0 | (imm<<16) lands in ALUOut.
      OP_LUI:  begin cls_o.imm = 1'b1; alu_ctl_o = ALU_OR;  ext_op_o = EXT_LUI;  end
      OP_J:    cls_o.j   = 1'b1;
      OP_JAL:  cls_o.jal = 1'b1;
      default: cls_o.nop = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multi-cycle MIPS control FSM: sequences the shared datapath and counts retired
// instructions. Define MC_MEM_WAIT_EN to add a mem_ready handshake on memory states.
module mc_controller
  import mc_defs::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       op,
  input  logic [5:0]       funct,
  input  logic             zero,
`ifdef MC_MEM_WAIT_EN
  input  logic             mem_ready,
`endif
  output logic             PCEn,
  output logic             IRWrite,
  output logic             MemWrite,
  output logic             RegWrite,
  output logic [1:0]       RegDst,
  output logic [1:0]       MemtoReg,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [2:0]       ALUControl,
  output logic [1:0]       ExtOp,
  output logic [1:0]       PCSrc,
  output logic [3:0]       state,
  output logic             instr_done,
  output logic [CNT_W-1:0] instr_cnt
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  iclass_t          cls;
  logic [2:0]       dec_alu;
  logic [1:0]       dec_ext;
  logic             mem_rdy;

`ifdef MC_MEM_WAIT_EN
  assign mem_rdy = mem_ready;
`else
  assign mem_rdy = 1'b1;
`endif

  mc_decode u_decode (
    .op_i      (op),
    .funct_i   (funct),
    .cls_o     (cls),
    .alu_ctl_o (dec_alu),
    .ext_op_o  (dec_ext)
  );

  always_comb begin
    state_d    = S_FETCH;
    PCEn       = 1'b0;
    IRWrite    = 1'b0;
    MemWrite   = 1'b0;
    RegWrite   = 1'b0;
    RegDst     = REGDST_RT;
    MemtoReg   = M2R_ALUOUT;
    ALUSrcA    = 1'b0;
    ALUSrcB    = SRCB_B;
    ALUControl = ALU_AND;
    ExtOp      = EXT_ZERO;
    PCSrc      = PCSRC_ALU;
    instr_done = 1'b0;
    case (state_q)
      S_FETCH: begin
        IRWrite    = mem_rdy;
        PCEn       = mem_rdy;
        ALUSrcB    = SRCB_4;
        ALUControl = ALU_ADD;
        state_d    = mem_rdy ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        // Branch target is computed speculatively into ALUOut.
        ALUSrcB    = SRCB_IMMSH;
        ExtOp      = EXT_SIGN;
        ALUControl = ALU_ADD;
        case (1'b1)
          cls.mem:   state_d = S_MEMADR;
          cls.rtype: state_d = S_RTYPE_EX;
          cls.imm:   state_d = S_IMM_EX;
          cls.beq:   state_d = S_BEQ_EX;
          cls.j:     state_d = S_JUMP;
          cls.jal:   state_d = S_JAL;
          cls.jr:    state_d = S_JR;
          cls.nop:   instr_done = 1'b1;
          default:   instr_done = 1'b1;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = SRCB_IMM;
        ExtOp      = EXT_SIGN;
        ALUControl = ALU_ADD;
        state_d    = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: state_d = mem_rdy ? S_MEMWB : S_MEMRD;
      S_MEMWB: begin
        RegWrite   = 1'b1;
        MemtoReg   = M2R_MDR;
        instr_done = 1'b1;
      end
      S_MEMWR: begin
        MemWrite   = 1'b1;
        instr_done = mem_rdy;
        state_d    = mem_rdy ? S_FETCH : S_MEMWR;
      end
      S_RTYPE_EX: begin
        ALUSrcA    = 1'b1;
        ALUControl = dec_alu;
        state_d    = S_RTYPE_WB;
      end
      S_RTYPE_WB: begin
        RegWrite   = 1'b1;
        RegDst     = REGDST_RD;
        instr_done = 1'b1;
      end
      S_IMM_EX: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = SRCB_IMM;
        ALUControl = dec_alu;
        ExtOp      = dec_ext;
        state_d    = S_IMM_WB;
      end
      S_IMM_WB: begin
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_BEQ_EX: begin
        ALUSrcA    = 1'b1;
        ALUControl = ALU_SUB;
        PCSrc      = PCSRC_ALUOUT;
        PCEn       = zero;
        instr_done = 1'b1;
      end
      S_JUMP: begin
        PCSrc      = PCSRC_JUMP;
        PCEn       = 1'b1;
        instr_done = 1'b1;
      end
      S_JAL: begin
        // PC already holds the return address (+4 from FETCH).
        PCSrc      = PCSRC_JUMP;
        PCEn       = 1'b1;
        RegWrite   = 1'b1;
        RegDst     = REGDST_RA;
        MemtoReg   = M2R_PC;
        instr_done = 1'b1;
      end
      S_JR: begin
        PCSrc      = PCSRC_REG;
        PCEn       = 1'b1;
        instr_done = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
    if (reset) begin
      PCEn       = 1'b0;
      IRWrite    = 1'b0;
      MemWrite   = 1'b0;
      RegWrite   = 1'b0;
      instr_done = 1'b0;
    end
  end

  assign cnt_d = instr_done ? cnt_q + CNT_W'(1) : cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign state     = state_q;
  assign instr_cnt = cnt_q;

endmodule
